// File: rtl/store_write_buffer.sv
// Store write buffer: queues accumulator stores and drains them, oldest first, to the data RAM write port.
// Latency: a store pushed into an empty buffer is presented on o_MEM_* one clock later; drains 1 entry/clk while i_MEM_ACK is held.
// Backpressure: o_WR_READY drops when all DEPTH entries are occupied; a store while full is dropped and sets sticky o_OVF.
//
// Ports:
//   i_clock / i_reset              rising-edge clock, asynchronous active-low reset
//   i_WR, i_WR_ADDR, i_WR_DATA     store request (1-cycle pulse), o_WR_READY = buffer can accept
//   i_RD_ADDR -> o_FWD_HIT/DATA    load-address lookup; youngest matching queued store wins
//   o_MEM_WE/ADDR/DATA, i_MEM_ACK  head entry write request to data RAM, popped on ack
//   o_COUNT, o_OVF                 occupancy and sticky overflow flag
// Optional feature: define STORE_COALESCE_EN to merge a store into the youngest entry when the addresses match.
module store_write_buffer #(
  parameter int N_BUS  = 16,
  parameter int N_ADDR = 11,
  parameter int DEPTH  = 4
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_WR,
  input  logic [N_ADDR-1:0]        i_WR_ADDR,
  input  logic [N_BUS-1:0]         i_WR_DATA,
  output logic                     o_WR_READY,
  input  logic [N_ADDR-1:0]        i_RD_ADDR,
  output logic                     o_FWD_HIT,
  output logic [N_BUS-1:0]         o_FWD_DATA,
  output logic                     o_MEM_WE,
  output logic [N_ADDR-1:0]        o_MEM_ADDR,
  output logic [N_BUS-1:0]         o_MEM_DATA,
  input  logic                     i_MEM_ACK,
  output logic [$clog2(DEPTH):0]   o_COUNT,
  output logic                     o_OVF
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Entry storage carries no reset: validity is tracked by vld_q and count_q.
  logic [N_ADDR-1:0] addr_q [DEPTH];
  logic [N_ADDR-1:0] addr_d [DEPTH];
  logic [N_BUS-1:0]  data_q [DEPTH];
  logic [N_BUS-1:0]  data_d [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;

  logic              not_empty;
  logic              not_full;
  logic              pop;
  logic              push;
  logic              coalesce;
  logic              wr_ready;
  logic              fwd_hit;
  logic [N_BUS-1:0]  fwd_data;
  logic [PTR_W-1:0]  fwd_idx;

`ifdef STORE_COALESCE_EN
  logic [PTR_W-1:0]  young_ptr;
  logic              coal_match;
`endif

  // Handshake decode.
  always_comb begin
    not_empty = (count_q != '0);
    not_full  = (count_q != FULL_CNT);
    pop       = not_empty && i_MEM_ACK;
`ifdef STORE_COALESCE_EN
    young_ptr = tail_q - PTR_W'(1);
    // The youngest entry cannot be merged into if it is leaving as the head this cycle.
    coal_match = vld_q[young_ptr] && (addr_q[young_ptr] == i_WR_ADDR) &&
                 !(pop && (young_ptr == head_q));
    wr_ready   = not_full || coal_match;
    coalesce   = i_WR && coal_match;
`else
    wr_ready   = not_full;
    coalesce   = 1'b0;
`endif
    push = i_WR && wr_ready && !coalesce;
  end

  // Next-state: queue pointers, occupancy, entries, overflow flag.
  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    vld_d   = vld_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    if (i_WR && !wr_ready) begin
      ovf_d = 1'b1;
    end

    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PTR_W'(1);
    end

    // Push never lands on the popped slot: push requires not full, pop requires not empty,
    // so head and tail differ whenever both happen.
    if (push) begin
      addr_d[tail_q] = i_WR_ADDR;
      data_d[tail_q] = i_WR_DATA;
      vld_d[tail_q]  = 1'b1;
      tail_d         = tail_q + PTR_W'(1);
    end

`ifdef STORE_COALESCE_EN
    if (coalesce) begin
      data_d[young_ptr] = i_WR_DATA;
    end
`endif

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      vld_q   <= vld_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge i_clock) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  // Forwarding: walk from oldest to youngest so the last match (nearest tail) wins.
  // The head being popped this cycle is still valid here, so it still forwards.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head_q + PTR_W'(k);
      if (vld_q[fwd_idx] && (addr_q[fwd_idx] == i_RD_ADDR)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end

  assign o_WR_READY = wr_ready;
  assign o_FWD_HIT  = fwd_hit;
  assign o_FWD_DATA = fwd_data;
  assign o_MEM_WE   = not_empty;
  // Zero the RAM bus when idle so stale entry contents never appear on it.
  assign o_MEM_ADDR = not_empty ? addr_q[head_q] : '0;
  assign o_MEM_DATA = not_empty ? data_q[head_q] : '0;
  assign o_COUNT    = count_q;
  assign o_OVF      = ovf_q;

endmodule
